// File: rtl/pc_pkg.sv
// Shared types and decode for the parametrised program counter.
// Optional feature macro: PC_BRANCH_EN (PC-relative branch). When it is
// undefined, branch requests are ignored by the decode.
package pc_pkg;

   typedef enum logic [2:0] {
      OP_HOLD,
      OP_INC,
      OP_BRANCH,
      OP_LOAD,
      OP_CALL,
      OP_RET
   } pc_op_e;

`ifdef PC_BRANCH_EN
   localparam bit BRANCH_EN = 1'b1;
`else
   localparam bit BRANCH_EN = 1'b0;
`endif

   // Exactly one action per edge: ret > call > load > branch > inc > hold.
   // Reset is handled by the caller and overrides all of these.
   function automatic pc_op_e pc_decode(input logic ret,
                                        input logic call,
                                        input logic load,
                                        input logic branch,
                                        input logic inc);
      pc_op_e op;
      if (ret)                       op = OP_RET;
      else if (call)                 op = OP_CALL;
      else if (load)                 op = OP_LOAD;
      else if (branch && BRANCH_EN)  op = OP_BRANCH;
      else if (inc)                  op = OP_INC;
      else                           op = OP_HOLD;
      return op;
   endfunction

endpackage

// File: rtl/pc_call_stack_ret_stack.sv
// Return-address LIFO. Only the occupancy counter is reset; the storage keeps
// its contents across reset. A push when full and a pop when empty are
// ignored here; the parent reports them as errors.
module ret_stack
   import pc_pkg::*;
#(
   parameter int unsigned W     = 16,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned SPW  = $clog2(DEPTH + 1)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           push,
   input  logic           pop,
   input  logic [W-1:0]   wdata,
   output logic [W-1:0]   rdata,
   output logic [SPW-1:0] sp,
   output logic           full,
   output logic           empty
);

   logic [SPW-1:0] sp_q, sp_d;
   logic [W-1:0]   mem_q [DEPTH];
   logic [W-1:0]   mem_d [DEPTH];

   assign sp    = sp_q;
   assign full  = (sp_q == SPW'(DEPTH));
   assign empty = (sp_q == '0);

   // Top-of-stack read: entry sp-1, zero when empty.
   always_comb begin
      rdata = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!empty && (SPW'(i) == sp_q - SPW'(1))) rdata = mem_q[i];
      end
   end

   // Next occupancy and storage; pop wins if both are requested.
   always_comb begin
      sp_d  = sp_q;
      mem_d = mem_q;
      if (pop && !empty) begin
         sp_d = sp_q - SPW'(1);
      end else if (push && !full) begin
         sp_d = sp_q + SPW'(1);
         for (int i = 0; i < DEPTH; i++) begin
            if (SPW'(i) == sp_q) mem_d[i] = wdata;
         end
      end
   end

   // Occupancy register, cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) sp_q <= '0;
      else       sp_q <= sp_d;
   end

   // Storage register, deliberately not reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/pc_call_stack.sv
// Parametrised program counter with inc, load, call/ret through an internal
// return-address stack, and an optional PC-relative branch guarded by the
// PC_BRANCH_EN macro. Without the macro the branch/offset ports stay on the
// interface but are ignored and no offset adder is built.
module pc_call_stack
   import pc_pkg::*;
#(
   parameter int unsigned W        = 16,
   parameter int unsigned STEP     = 1,
   parameter int unsigned DEPTH    = 4,
   parameter logic [W-1:0] RESET_PC = '0,
   localparam int unsigned SPW     = $clog2(DEPTH + 1)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [W-1:0]   d_in,
   input  logic [W-1:0]   offset,
   input  logic           inc,
   input  logic           load,
   input  logic           branch,
   input  logic           call,
   input  logic           ret,
   output logic [W-1:0]   d_out,
   output logic [SPW-1:0] sp,
   output logic           full,
   output logic           empty,
   output logic           err
);

   logic [W-1:0] d_out_q, d_out_d;
   logic         err_q, err_d;
   logic [W-1:0] seq_pc;
   logic [W-1:0] branch_pc;
   logic [W-1:0] top_data;
   logic         push, pop;
   pc_op_e       op;

   assign d_out = d_out_q;
   assign err   = err_q;

   // Sequential successor; also the return address pushed by call.
   assign seq_pc = d_out_q + W'(STEP);

`ifdef PC_BRANCH_EN
   // Two's-complement add is the same as unsigned add modulo 2^W.
   assign branch_pc = d_out_q + offset;
`else
   logic unused_offset;
   assign unused_offset = ^offset;
   assign branch_pc     = d_out_q;
`endif

   // Priority decode of the control inputs into a single action.
   always_comb begin
      op = pc_decode(ret, call, load, branch, inc);
   end

   // Stack requests; suppressed in the reset cycle so nothing is written.
   always_comb begin
      push = !reset && (op == OP_CALL);
      pop  = !reset && (op == OP_RET);
   end

   ret_stack #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_ret_stack (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (seq_pc),
      .rdata (top_data),
      .sp    (sp),
      .full  (full),
      .empty (empty)
   );

   // Next-PC mux and fault detection (overflowing call still jumps).
   always_comb begin
      d_out_d = d_out_q;
      err_d   = 1'b0;
      case (op)
         OP_INC:    d_out_d = seq_pc;
         OP_BRANCH: d_out_d = branch_pc;
         OP_LOAD:   d_out_d = d_in;
         OP_CALL: begin
            d_out_d = d_in;
            err_d   = full;
         end
         OP_RET: begin
            if (empty) err_d = 1'b1;
            else       d_out_d = top_data;
         end
         default:   d_out_d = d_out_q;
      endcase
   end

   // PC and error-pulse registers; reset overrides any request.
   always_ff @(posedge clk) begin
      if (reset) begin
         d_out_q <= RESET_PC;
         err_q   <= 1'b0;
      end else begin
         d_out_q <= d_out_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_pc_call_stack.sv
// Directed bench for pc_call_stack (W=16, STEP=1, DEPTH=4, RESET_PC=0).
module tb_pc_call_stack;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] d_in = '0;
   logic [15:0] offset = '0;
   logic        inc = 1'b0, load = 1'b0, branch = 1'b0, call = 1'b0, ret = 1'b0;
   logic [15:0] d_out;
   logic [2:0]  sp;
   logic        full, empty, err;

   int checks = 0;
   int failures = 0;

   pc_call_stack #(.W(16), .STEP(1), .DEPTH(4), .RESET_PC(16'h0000)) dut (
      .clk(clk), .reset(reset), .d_in(d_in), .offset(offset),
      .inc(inc), .load(load), .branch(branch), .call(call), .ret(ret),
      .d_out(d_out), .sp(sp), .full(full), .empty(empty), .err(err)
   );

   always #5 clk = ~clk;

   // Drop all controls.
   task automatic idle();
      reset = 0; inc = 0; load = 0; branch = 0; call = 0; ret = 0;
   endtask

   // Advance one edge and settle away from it; controls are cleared after.
   task automatic tick();
      @(posedge clk); #1;
      idle();
   endtask

   task automatic test_reset();
      reset = 1; inc = 1; tick();
      checks++; if (d_out !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", d_out, 16'h0000); end
      checks++; if (sp !== 3'd0) begin failures++; $display("FAIL reset_sp got=%0d exp=0", sp); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
      checks++; if ({full, empty} !== 2'b01) begin failures++; $display("FAIL reset_flags got=%b exp=01", {full, empty}); end
   endtask

   task automatic test_inc();
      for (int i = 1; i <= 3; i++) begin
         inc = 1; tick();
         checks++; if (d_out !== 16'(i)) begin failures++; $display("FAIL inc%0d got=%h exp=%h", i, d_out, 16'(i)); end
      end
      checks++; if (sp !== 3'd0 || empty !== 1'b1) begin failures++; $display("FAIL inc_stack sp=%0d empty=%b exp sp=0 empty=1", sp, empty); end
      tick();
      checks++; if (d_out !== 16'h0003) begin failures++; $display("FAIL hold got=%h exp=0003", d_out); end
   endtask

   task automatic test_wrap();
      load = 1; d_in = 16'hFFFE; tick();
      checks++; if (d_out !== 16'hFFFE) begin failures++; $display("FAIL load got=%h exp=FFFE", d_out); end
      inc = 1; tick();
      checks++; if (d_out !== 16'hFFFF) begin failures++; $display("FAIL wrap1 got=%h exp=FFFF", d_out); end
      inc = 1; tick();
      checks++; if (d_out !== 16'h0000) begin failures++; $display("FAIL wrap2 got=%h exp=0000", d_out); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL wrap_err got=%b exp=0", err); end
   endtask

   task automatic test_branch();
      logic [15:0] exp1, exp2;
`ifdef PC_BRANCH_EN
      exp1 = 16'h0008; exp2 = 16'h000C;
`else
      exp1 = 16'h0010; exp2 = 16'h0011;
`endif
      load = 1; d_in = 16'h0010; tick();
      branch = 1; offset = 16'hFFF8; tick();
      checks++; if (d_out !== exp1) begin failures++; $display("FAIL branch_neg got=%h exp=%h", d_out, exp1); end
      // branch outranks inc when enabled; otherwise inc is taken
      branch = 1; inc = 1; offset = 16'h0004; tick();
      checks++; if (d_out !== exp2) begin failures++; $display("FAIL branch_inc got=%h exp=%h", d_out, exp2); end
   endtask

   task automatic test_call_ret();
      logic [15:0] tgt [4];
      logic [15:0] rtn [4];
      tgt = '{16'd100, 16'd200, 16'd300, 16'd400};
      rtn = '{16'd301, 16'd201, 16'd101, 16'd6};
      load = 1; d_in = 16'd5; tick();
      for (int i = 0; i < 4; i++) begin
         call = 1; d_in = tgt[i]; tick();
         checks++; if (d_out !== tgt[i] || sp !== 3'(i + 1)) begin failures++; $display("FAIL call%0d pc=%0d sp=%0d exp pc=%0d sp=%0d", i, d_out, sp, tgt[i], i + 1); end
      end
      checks++; if (full !== 1'b1 || empty !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL full_flags full=%b empty=%b err=%b exp 1 0 0", full, empty, err); end
      call = 1; d_in = 16'd500; tick();
      checks++; if (d_out !== 16'd500 || sp !== 3'd4) begin failures++; $display("FAIL overflow pc=%0d sp=%0d exp pc=500 sp=4", d_out, sp); end
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL overflow_err got=%b exp=1", err); end
      tick();
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL overflow_err_clr got=%b exp=0", err); end
      for (int i = 0; i < 4; i++) begin
         ret = 1; tick();
         checks++; if (d_out !== rtn[i] || sp !== 3'(3 - i)) begin failures++; $display("FAIL ret%0d pc=%0d sp=%0d exp pc=%0d sp=%0d", i, d_out, sp, rtn[i], 3 - i); end
      end
      checks++; if (empty !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL empty_flags empty=%b err=%b exp 1 0", empty, err); end
      ret = 1; tick();
      checks++; if (d_out !== 16'd6 || sp !== 3'd0) begin failures++; $display("FAIL underflow pc=%0d sp=%0d exp pc=6 sp=0", d_out, sp); end
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL underflow_err got=%b exp=1", err); end
      tick();
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL underflow_err_clr got=%b exp=0", err); end
   endtask

   task automatic test_simultaneous();
      load = 1; d_in = 16'd7; tick();
      call = 1; load = 1; inc = 1; d_in = 16'd40; tick();
      checks++; if (d_out !== 16'd40 || sp !== 3'd1) begin failures++; $display("FAIL call_wins pc=%0d sp=%0d exp pc=40 sp=1", d_out, sp); end
      ret = 1; call = 1; d_in = 16'd99; tick();
      checks++; if (d_out !== 16'd8 || sp !== 3'd0) begin failures++; $display("FAIL ret_wins pc=%0d sp=%0d exp pc=8 sp=0", d_out, sp); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL ret_wins_err got=%b exp=0", err); end
   endtask

   task automatic test_reset_mid();
      load = 1; d_in = 16'd10; tick();
      call = 1; d_in = 16'd20; tick();
      call = 1; d_in = 16'd30; tick();
      checks++; if (sp !== 3'd2) begin failures++; $display("FAIL mid_sp got=%0d exp=2", sp); end
      reset = 1; ret = 1; tick();
      checks++; if (d_out !== 16'd0 || sp !== 3'd0 || err !== 1'b0) begin failures++; $display("FAIL reset_ret pc=%0d sp=%0d err=%b exp 0 0 0", d_out, sp, err); end
      ret = 1; tick();
      checks++; if (d_out !== 16'd0 || err !== 1'b1 || sp !== 3'd0) begin failures++; $display("FAIL post_reset_ret pc=%0d err=%b sp=%0d exp 0 1 0", d_out, err, sp); end
      // a call during reset must not push or flag
      reset = 1; call = 1; d_in = 16'd77; tick();
      checks++; if (d_out !== 16'd0 || sp !== 3'd0 || err !== 1'b0) begin failures++; $display("FAIL reset_call pc=%0d sp=%0d err=%b exp 0 0 0", d_out, sp, err); end
   endtask

   initial begin
      test_reset();
      test_inc();
      test_wrap();
      test_branch();
      test_call_ret();
      test_simultaneous();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
